// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light front-end and controller:
// walk FSM encodings, default timing constants and input-vector indices.
package traffic_pkg;

    // Walk request FSM; W_LOCKOUT is only reachable when the
    // post-service lockout is built in (WALK_LOCKOUT_EN).
    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_PENDING = 2'd1,
        W_HOLD    = 2'd2,
        W_LOCKOUT = 2'd3
    } walk_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 2;
    localparam int LOCKOUT_CYCLES_DEF  = 10;

    // Raw inputs are conditioned as one small vector.
    localparam int NUM_INPUTS = 2;
    localparam int IDX_WALK   = 0;
    localparam int IDX_SENSOR = 1;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// level only flips after DEBOUNCE_CYCLES consecutive differing samples,
// so raw edge to stable change takes 2 + DEBOUNCE_CYCLES edges.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer shift and debounce counter next-state.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/traffic_input_conditioner.sv
// Front-end for the traffic light controller: debounces the walk button
// and vehicle sensor, latches a single walk request until acknowledged,
// and pulses sensor_rise on each new vehicle arrival.
// Optional macro WALK_LOCKOUT_EN adds a post-service lockout window in
// which new walk presses are dropped.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic walk_button,
    input  logic sensor,
    input  logic walk_ack,
    output logic walk_request,
    output logic sensor_active,
    output logic sensor_rise,
    output logic walk_locked
);

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] stable_vec;
    logic [NUM_INPUTS-1:0] stable_dly_q, stable_dly_d;

    logic        walk_stable, walk_rise, sensor_stable;
    walk_state_e state_q, state_d;
    logic        walk_request_q, walk_request_d;
    logic        sensor_rise_q, sensor_rise_d;
    logic        walk_locked_q, walk_locked_d;

    assign raw_vec[IDX_WALK]   = walk_button;
    assign raw_vec[IDX_SENSOR] = sensor;

    // One debouncer per raw input.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .raw_in    (raw_vec[gi]),
            .stable_out(stable_vec[gi])
        );
    end

    assign walk_stable   = stable_vec[IDX_WALK];
    assign sensor_stable = stable_vec[IDX_SENSOR];
    assign walk_rise     = walk_stable & ~stable_dly_q[IDX_WALK];

`ifdef WALK_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;

    // Lockout down-counter: loaded on HOLD exit, counts to zero in LOCKOUT.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == W_HOLD && !walk_stable) begin
            lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
        end else if (state_q == W_LOCKOUT && lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - LW'(1);
        end
    end

    // Lockout counter register.
    always_ff @(posedge clk) begin
        if (rst) lock_cnt_q <= '0;
        else     lock_cnt_q <= lock_cnt_d;
    end
`endif

    // Walk FSM next state; an ack outside W_PENDING is ignored, and a rise
    // while already pending is absorbed into the single request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:    if (walk_rise) state_d = W_PENDING;
            W_PENDING: if (walk_ack)  state_d = W_HOLD;
`ifdef WALK_LOCKOUT_EN
            W_HOLD:    if (!walk_stable) state_d = W_LOCKOUT;
            W_LOCKOUT: if (lock_cnt_q == '0) state_d = W_IDLE;
`else
            W_HOLD:    if (!walk_stable) state_d = W_IDLE;
`endif
            default:   state_d = W_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state so they line up with
    // the state register; sensor_rise compares against last cycle's level.
    always_comb begin
        stable_dly_d   = stable_vec;
        walk_request_d = (state_d == W_PENDING);
        sensor_rise_d  = sensor_stable & ~stable_dly_q[IDX_SENSOR];
`ifdef WALK_LOCKOUT_EN
        walk_locked_d  = (state_d == W_LOCKOUT);
`else
        walk_locked_d  = 1'b0;
`endif
    end

    // FSM and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= W_IDLE;
            stable_dly_q   <= '0;
            walk_request_q <= 1'b0;
            sensor_rise_q  <= 1'b0;
            walk_locked_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            stable_dly_q   <= stable_dly_d;
            walk_request_q <= walk_request_d;
            sensor_rise_q  <= sensor_rise_d;
            walk_locked_q  <= walk_locked_d;
        end
    end

    assign walk_request  = walk_request_q;
    assign sensor_active = sensor_stable;
    assign sensor_rise   = sensor_rise_q;
    assign walk_locked   = walk_locked_q;

endmodule

// File: doc/traffic_input_conditioner.md
Name: traffic_input_conditioner

Overview:
Upstream front-end for the traffic light controller. It synchronizes and debounces the raw pedestrian walk button and the side-street vehicle sensor, then presents clean signals downstream:
- walk_request: latched pedestrian request, held until the controller acknowledges it.
- sensor_active: debounced vehicle-presence level.
- sensor_rise: one-cycle pulse on a new vehicle arrival.

Parameters:
- DEBOUNCE_CYCLES, 2: consecutive stable synchronized samples required before a debounced output changes (min 1).
- LOCKOUT_CYCLES, 10: post-service cycles during which new walk presses are ignored (used only with WALK_LOCKOUT_EN).

Ports:
- clk  in  1  system clock (1 Hz tick in the lab build)
- rst  in  1  synchronous, active-high reset
- walk_button  in  1  raw pedestrian button, asynchronous, bouncy
- sensor  in  1  raw vehicle sensor, asynchronous, bouncy
- walk_ack  in  1  one-cycle pulse from the controller when the walk phase begins
- walk_request  out  1  latched walk request to the controller
- sensor_active  out  1  debounced sensor level
- sensor_rise  out  1  one-cycle pulse on debounced sensor 0->1
- walk_locked  out  1  high during post-service lockout (constant 0 without WALK_LOCKOUT_EN)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: sync flops, debounce counters, debounced levels and edge-detect flops all clear to 0. FSM goes to W_IDLE. All outputs are 0 on the first edge with rst=1. Reset mid-operation discards any pending request or lockout.
- Synchronizer: 2-flop chain per raw input. Raw value is visible at the sync output 2 edges after it is sampled.
- Debouncer, per input:
  - Counter width is clog2(DEBOUNCE_CYCLES)+1.
  - While sync != stable, the counter increments. When it reaches DEBOUNCE_CYCLES-1 with sync still differing, stable flips at the next edge and the counter clears.
  - Any cycle with sync == stable clears the counter. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency, raw edge to debounced change: 2+DEBOUNCE_CYCLES edges (4 at default).
- sensor_active equals stable_sensor.
- sensor_rise = stable_sensor & ~stable_sensor_d, registered. It is high for exactly 1 cycle, one edge after sensor_active rises. A falling sensor produces no pulse.
- Walk FSM, states W_IDLE, W_PENDING, W_HOLD (plus W_LOCKOUT with the macro):
  - W_IDLE -> W_PENDING on a debounced walk rise.
  - W_PENDING -> W_HOLD on walk_ack. Further presses in W_PENDING are absorbed (single request).
  - W_HOLD -> W_IDLE once the debounced walk level is 0. A button held through service cannot re-arm until it is released and pressed again.
  - walk_ack in W_IDLE or W_HOLD is ignored.
  - Debounced rise and walk_ack in the same cycle in W_IDLE: enter W_PENDING (ack ignored).
- walk_request = (state == W_PENDING), registered. Raw press to walk_request high is 5 edges at default. It drops on the edge after walk_ack.

Optional Feature:
- Macro WALK_LOCKOUT_EN.
- Defined: W_HOLD exits to W_LOCKOUT instead of W_IDLE.
  - A down-counter loads LOCKOUT_CYCLES-1 and W_LOCKOUT -> W_IDLE when it reaches 0, so the lockout lasts LOCKOUT_CYCLES cycles.
  - Presses during lockout are dropped, not queued.
  - walk_locked = (state == W_LOCKOUT).
- Undefined: no lockout state or counter; W_HOLD -> W_IDLE directly; walk_locked tied to 0.

Decomposition:
- Shared package/include traffic_pkg: walk FSM state encodings (2-bit) and default DEBOUNCE_CYCLES / LOCKOUT_CYCLES constants, reused by the controller.
- One sub-module, input_debouncer (synchronizer + counter + stable level, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan:
- rst=1 for 2 cycles with both raw inputs at 1 -> all outputs 0 throughout reset; after release, sensor_active rises 4 edges later.
- walk_button high 1 cycle (shorter than DEBOUNCE_CYCLES=2) -> walk_request never asserts. Held 3 cycles -> walk_request high at edge 5, stays high until walk_ack, drops on the following edge.
- walk_button held 20 cycles with walk_ack at cycle 8 -> exactly one request; no re-arm until release plus a fresh press, which re-asserts walk_request 5 edges after that press.
- sensor pulse 0->1 held 5 cycles -> sensor_active high 4 edges after the rise; sensor_rise high for exactly 1 cycle; no pulse on the fall.
- Simultaneous debounced walk rise and walk_ack in W_IDLE -> walk_request asserts; reset asserted while walk_request=1 -> walk_request 0 on the next edge.
- WALK_LOCKOUT_EN defined, LOCKOUT_CYCLES=4: release after service, then press during lockout -> walk_locked=1 for 4 cycles, the press is ignored, and a press after lockout asserts walk_request.
